// File: rtl/branch_comp_seq.sv
// branch_comp_seq: multi-cycle RISC-V branch comparator.
// Compares two N-bit operands CHUNK bits at a time, most significant chunk
// first, and reports BrEq, BrLt, illegal and the branch-taken decision for
// funct3. Valid/ready handshakes sit on both the input and output sides.
// A synchronous flush abandons any operation in progress.
// Optional feature macro: BRANCH_COMP_EARLY_EXIT_EN. When it is defined, the
// block finishes as soon as the first differing chunk settles the result.
module branch_comp_seq #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] br_data0,
  input  logic [N-1:0] br_data1,
  input  logic [2:0]   funct3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         BrEq,
  output logic         BrLt,
  output logic         taken,
  output logic         illegal
);

  localparam int K  = N / CHUNK;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    op0_q;
  logic [N-1:0]    op1_q;
  logic [2:0]      f3_q;
  logic [CW-1:0]   cnt;
  logic            decided;
  logic            lt_rec;

  logic [N-1:0]    msb_mask;
  logic [CHUNK-1:0] top0;
  logic [CHUNK-1:0] top1;
  logic            chunk_diff;
  logic            chunk_lt;
  logic            last_chunk;
  logic            finish;
  logic            eq_final;
  logic            lt_final;

  // Branch decision from the comparison flags; reserved encodings never take.
  function automatic logic taken_of(input logic [2:0] f, input logic eq, input logic lt);
    case (f)
      3'b000:         taken_of = eq;
      3'b001:         taken_of = !eq;
      3'b100, 3'b110: taken_of = lt;
      3'b101, 3'b111: taken_of = !lt;
      default:        taken_of = 1'b0;
    endcase
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so every chunk can use a plain unsigned comparison.
  assign msb_mask = funct3[1] ? '0 : {1'b1, {(N-1){1'b0}}};

  // The operand registers shift left each cycle, so the chunk under test is
  // always the top CHUNK bits.
  assign top0       = op0_q[N-1 -: CHUNK];
  assign top1       = op1_q[N-1 -: CHUNK];
  assign chunk_diff = (top0 != top1);
  assign chunk_lt   = (top0 < top1);
  assign last_chunk = (cnt == CW'(K - 1));

  // The first differing chunk decides the result; later chunks cannot change it.
  assign eq_final = !(decided || chunk_diff);
  assign lt_final = decided ? lt_rec : (chunk_diff && chunk_lt);

`ifdef BRANCH_COMP_EARLY_EXIT_EN
  assign finish = last_chunk || (!decided && chunk_diff);
`else
  assign finish = last_chunk;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid)  state_nxt = BUSY;
        BUSY:    if (finish)    state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, chunk walk and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op0_q   <= '0;
      op1_q   <= '0;
      f3_q    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      lt_rec  <= 1'b0;
      BrEq    <= 1'b0;
      BrLt    <= 1'b0;
      taken   <= 1'b0;
      illegal <= 1'b0;
    end else if (flush) begin
      cnt     <= '0;
      decided <= 1'b0;
      lt_rec  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op0_q   <= br_data0 ^ msb_mask;
            op1_q   <= br_data1 ^ msb_mask;
            f3_q    <= funct3;
            cnt     <= '0;
            decided <= 1'b0;
            lt_rec  <= 1'b0;
          end
        end
        BUSY: begin
          op0_q <= op0_q << CHUNK;
          op1_q <= op1_q << CHUNK;
          cnt   <= cnt + CW'(1);
          if (!decided && chunk_diff) begin
            decided <= 1'b1;
            lt_rec  <= chunk_lt;
          end
          if (finish) begin
            BrEq    <= eq_final;
            BrLt    <= lt_final;
            illegal <= (f3_q[2:1] == 2'b01);
            taken   <= taken_of(f3_q, eq_final, lt_final);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/branch_comp_seq.md
Name: branch_comp_seq

Overview:
- Parametrised multi-cycle successor to the combinational branch comparator in riscv_core.
- Compares two N-bit operands in CHUNK-bit slices, MSB-first, over N/CHUNK cycles. Produces BrEq, BrLt and a RISC-V branch-taken decision from funct3.
- Valid/ready handshakes on both sides; a synchronous flush input for pipeline kills. Intended for area-reduced or wide-datapath configurations.

Parameters:
- N, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; K = N/CHUNK cycles per operation (CHUNK = N gives K = 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill; abandon any operation.
- in_valid  in  1  operands and funct3 valid.
- in_ready  out  1  block can accept an operation.
- br_data0  in  N  operand rs1.
- br_data1  in  N  operand rs2.
- funct3  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- BrEq  out  1  br_data0 == br_data1.
- BrLt  out  1  br_data0 < br_data1; signed unless funct3[1] = 1.
- taken  out  1  branch-taken decision.
- illegal  out  1  funct3 was 010 or 011.

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready = 1; out_valid, BrEq, BrLt, taken and illegal = 0; counter, decided and lt_rec = 0.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). There is no overlap; a new op is accepted only in IDLE.
- IDLE: on in_valid & in_ready, capture operands and funct3, then go to BUSY with cnt = 0, decided = 0, lt_rec = 0.
- Signed mode (funct3[1] = 0): bit N-1 of both captured operands is inverted at capture, so every chunk then uses unsigned compare. Unsigned mode captures operands unmodified.
- BUSY, each cycle, chunk index K-1-cnt (MSB-first):
  - If !decided and chunks differ: decided <= 1, lt_rec <= (chunk0 < chunk1).
  - cnt increments.
  - After processing chunk 0 (cnt == K-1), go to DONE.
- Latency: out_valid rises exactly K cycles after the accepting edge. K = 4 at the defaults.
- Entering DONE, register the outputs:
  - BrEq = !decided_final
  - BrLt = lt_final
  - illegal = (funct3 == 010 or 011)
  - taken: BEQ = BrEq; BNE = !BrEq; BLT/BLTU = BrLt; BGE/BGEU = !BrLt; illegal cases = 0.
- DONE: out_valid = 1. All outputs are held stable while out_ready = 0. On out_ready, go to IDLE and clear out_valid the next cycle. BrEq, BrLt, taken and illegal may keep their last values after that.
- flush:
  - Has priority over every transition.
  - Next state is IDLE; out_valid = 0 and decided = 0.
  - An in_valid presented in the same cycle as flush is not accepted.
- Input changes during BUSY/DONE are ignored because operands are registered.
- Equal operands (including 0 vs 0 and all-ones vs all-ones) give BrEq = 1, BrLt = 0.
- Boundary values, signed: 0x80000000 < 0x7FFFFFFF. Unsigned: 0xFFFFFFFF > 0x00000000.

Optional Feature:
- Macro: BRANCH_COMP_EARLY_EXIT_EN.
- Defined: BUSY goes to DONE on the edge that first sets decided. Latency = index of the first differing chunk from the MSB, plus 1 (range 1..K). Equal operands still take K cycles. Results are identical to the non-early-exit build.
- Undefined: fixed latency of K cycles for every operation.

Test Plan:
- Reset then BLT, 0xFFFFFFFF vs 0x00000001 (signed -1 < 1), N=32, CHUNK=8 -> out_valid 4 cycles after accept; BrLt=1, BrEq=0, taken=1.
- BLTU with the same operands -> BrLt=0, taken=0. BGEU -> taken=1.
- BEQ 0x12345678 vs 0x12345678 -> BrEq=1, taken=1, latency 4. BNE -> taken=0. With BRANCH_COMP_EARLY_EXIT_EN, latency is still 4.
- BGE, 0x80000000 vs 0x7FFFFFFF -> BrLt=1, taken=0. With early exit, out_valid 1 cycle after accept.
- Hold out_ready=0 for 5 cycles in DONE -> outputs and out_valid stable, in_ready=0. Then pulse out_ready -> IDLE, in_ready=1.
- Assert flush in BUSY cycle 2, then rst_n low mid-BUSY on a second op -> each returns to IDLE, out_valid never asserts. funct3=010 afterwards -> illegal=1, taken=0.
